// File: rtl/update_unpack_x8.sv
// Rate-adapting unpacker: buffers up to two packed update lines and emits
// left-aligned beats sized by the consumer's per-cycle word request.
module update_unpack_x8 #(
  parameter int unsigned W     = 64,
  parameter int unsigned LANES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W*LANES-1:0]     in_word,
  input  logic [LANES-1:0]       in_valid_mask,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic [$clog2(LANES):0] out_req,
  output logic [W*LANES-1:0]     out_word,
  output logic [LANES-1:0]       out_valid_mask,
  output logic                   out_last
);
  localparam int unsigned CW = $clog2(LANES) + 1;
  localparam int unsigned LW = $clog2(LANES);
  typedef logic [CW-1:0] cnt_t;
  typedef logic [LW-1:0] lane_t;

  logic [W-1:0] s0_data [LANES];
  logic [W-1:0] s1_data [LANES];
  cnt_t         s0_cnt, s1_cnt, rd_ptr;
  logic         s0_full, s0_last, s1_full, s1_last;
  logic         in_ready_q;

  logic [W-1:0]       in_lanes [LANES];
  cnt_t               in_cnt;
  logic               in_run;
  cnt_t               req_c, avail0, avail1, grant, take0, take1;
  logic [CW:0]        avail;
  lane_t              idx;
  logic               s0_retire, s1_consumed, s0_keep, s1_shift, accept;
  logic [W*LANES-1:0] beat_word;
  logic [LANES-1:0]   beat_mask;
  logic               beat_last;

  assign in_ready = in_ready_q && !rst;
  assign accept   = in_ready && ((in_cnt != '0) || in_last);

  // Input word count is the run of leading ones; anything after the first 0 is ignored.
  always_comb begin
    in_cnt = '0;
    in_run = 1'b1;
    for (int unsigned i = 0; i < LANES; i++) begin
      in_lanes[i] = in_word[(LANES-1-i)*W +: W];
      if (in_run && in_valid_mask[LANES-1-i]) in_cnt = in_cnt + 1'b1;
      else                                    in_run = 1'b0;
    end
  end

  always_comb begin
    req_c       = (out_req > cnt_t'(LANES)) ? cnt_t'(LANES) : out_req;
    avail0      = s0_full ? cnt_t'(s0_cnt - rd_ptr) : '0;
    avail1      = (s0_full && !s0_last && s1_full) ? s1_cnt : '0;
    avail       = {1'b0, avail0} + {1'b0, avail1};
    grant       = ({1'b0, req_c} < avail) ? req_c : avail[CW-1:0];
    take0       = (grant < avail0) ? grant : avail0;
    take1       = grant - take0;
    // A last-tagged empty head has avail0 = 0, so it retires with the marker beat.
    s0_retire   = s0_full && (take0 == avail0);
    s1_consumed = s1_full && (s1_cnt != '0) && (take1 == s1_cnt);
    s0_keep     = s0_full && !s0_retire;
    s1_shift    = s0_retire && s1_full && !s1_consumed;
    beat_last   = (s0_retire && s0_last) || (s1_consumed && s1_last);
    beat_mask   = '0;
    beat_word   = '0;
    idx         = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      if (cnt_t'(j) < grant) begin
        beat_mask[LANES-1-j] = 1'b1;
        if (cnt_t'(j) < take0) begin
          idx = lane_t'(rd_ptr + cnt_t'(j));
          beat_word[(LANES-1-j)*W +: W] = s0_data[idx];
        end else begin
          idx = lane_t'(cnt_t'(j) - take0);
          beat_word[(LANES-1-j)*W +: W] = s1_data[idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_full        <= 1'b0;
      s0_cnt         <= '0;
      s0_last        <= 1'b0;
      s1_full        <= 1'b0;
      s1_cnt         <= '0;
      s1_last        <= 1'b0;
      rd_ptr         <= '0;
      in_ready_q     <= 1'b0;
      out_word       <= '0;
      out_valid_mask <= '0;
      out_last       <= 1'b0;
    end else begin
      out_word       <= beat_word;
      out_valid_mask <= beat_mask;
      out_last       <= beat_last;
      if (s0_retire) begin
        s0_full <= s1_shift;
        s0_cnt  <= s1_cnt;
        s0_last <= s1_last;
        rd_ptr  <= take1;
        s1_full <= 1'b0;
      end else begin
        rd_ptr  <= rd_ptr + take0;
      end
      // New line lands in the first slot still occupied-free after this cycle's drain.
      if (accept) begin
        if (s0_keep || s1_shift) begin
          s1_full <= 1'b1;
          s1_cnt  <= in_cnt;
          s1_last <= in_last;
        end else begin
          s0_full <= 1'b1;
          s0_cnt  <= in_cnt;
          s0_last <= in_last;
          rd_ptr  <= '0;
        end
      end
      in_ready_q <= !(s0_keep && s1_full) && !(accept && (s0_keep || s1_shift));
    end
  end

  always_ff @(posedge clk) begin
    if (s0_retire) s0_data <= s1_data;
    if (accept) begin
      if (s0_keep || s1_shift) s1_data <= in_lanes;
      else                     s0_data <= in_lanes;
    end
  end

endmodule

// File: tb/tb_update_unpack_x8.sv
// Directed bench for update_unpack_x8: hand-computed beats for the six scenarios.
module tb_update_unpack_x8;
  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] in_word;
  logic [7:0]   in_valid_mask;
  logic         in_last;
  logic         in_ready;
  logic [3:0]   out_req;
  logic [511:0] out_word;
  logic [7:0]   out_valid_mask;
  logic         out_last;

  int checks = 0;
  int errors = 0;

  update_unpack_x8 #(.W(64), .LANES(8)) dut (
    .clk(clk), .rst(rst),
    .in_word(in_word), .in_valid_mask(in_valid_mask), .in_last(in_last), .in_ready(in_ready),
    .out_req(out_req), .out_word(out_word), .out_valid_mask(out_valid_mask), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [15:0] tag, input int unsigned i);
    return {tag, 40'h0, 8'(i)};
  endfunction

  // Words tag[start .. start+n-1] placed at output lanes pos .. pos+n-1.
  function automatic logic [511:0] seg(input logic [15:0] tag, input int unsigned start,
                                       input int unsigned n, input int unsigned pos);
    logic [511:0] v;
    v = '0;
    for (int unsigned k = 0; k < n; k++) v[(7-(pos+k))*64 +: 64] = mk(tag, start + k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] tag, input logic [7:0] mask, input logic last);
    in_word       = seg(tag, 0, 8, 0);
    in_valid_mask = mask;
    in_last       = last;
  endtask

  task automatic idle();
    in_word       = '0;
    in_valid_mask = '0;
    in_last       = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input logic [511:0] ew, input logic [7:0] em,
                          input logic el);
    checks++;
    assert (out_word === ew) else begin
      errors++;
      $error("FAIL %s out_word got %h exp %h", tag, out_word, ew);
    end
    checks++;
    assert (out_valid_mask === em) else begin
      errors++;
      $error("FAIL %s out_valid_mask got %h exp %h", tag, out_valid_mask, em);
    end
    checks++;
    assert (out_last === el) else begin
      errors++;
      $error("FAIL %s out_last got %b exp %b", tag, out_last, el);
    end
  endtask

  task automatic chk_rdy(input string tag, input logic er);
    checks++;
    assert (in_ready === er) else begin
      errors++;
      $error("FAIL %s in_ready got %b exp %b", tag, in_ready, er);
    end
  endtask

  initial begin
    rst = 1'b1;
    out_req = 4'd0;
    idle();
    tick();
    tick();
    chk_rdy("rst_rdy", 1'b0);
    chk_beat("rst_out", '0, 8'h00, 1'b0);
    rst = 1'b0;
    tick();
    chk_rdy("rst_rise", 1'b1);

    // 1: back-to-back full lines at full rate; second request uses 15 (clamps to 8)
    offer(16'h00A0, 8'hFF, 1'b0);
    out_req = 4'd8;
    tick();
    chk_beat("t1_first", '0, 8'h00, 1'b0);
    chk_rdy("t1_rdy0", 1'b1);
    offer(16'h00B0, 8'hFF, 1'b0);
    tick();
    chk_beat("t1_A", seg(16'h00A0, 0, 8, 0), 8'hFF, 1'b0);
    chk_rdy("t1_rdy1", 1'b1);
    idle();
    out_req = 4'd15;
    tick();
    chk_beat("t1_B", seg(16'h00B0, 0, 8, 0), 8'hFF, 1'b0);
    chk_rdy("t1_rdy2", 1'b1);
    out_req = 4'd0;
    tick();
    chk_beat("t1_idle", '0, 8'h00, 1'b0);

    // 2: one full line drained three words at a time
    offer(16'h00C0, 8'hFF, 1'b0);
    out_req = 4'd3;
    tick();
    idle();
    tick();
    chk_beat("t2_b0", seg(16'h00C0, 0, 3, 0), 8'hE0, 1'b0);
    tick();
    chk_beat("t2_b1", seg(16'h00C0, 3, 3, 0), 8'hE0, 1'b0);
    tick();
    chk_beat("t2_b2", seg(16'h00C0, 6, 2, 0), 8'hC0, 1'b0);
    tick();
    chk_beat("t2_empty", '0, 8'h00, 1'b0);

    // 3: short line then full line, beats span both slots
    out_req = 4'd0;
    offer(16'h00D0, 8'hE0, 1'b0);
    tick();
    offer(16'h00E0, 8'hFF, 1'b0);
    tick();
    chk_rdy("t3_full", 1'b0);
    idle();
    out_req = 4'd5;
    tick();
    chk_beat("t3_b0", seg(16'h00D0, 0, 3, 0) | seg(16'h00E0, 0, 2, 3), 8'hF8, 1'b0);
    tick();
    chk_beat("t3_b1", seg(16'h00E0, 2, 5, 0), 8'hF8, 1'b0);
    tick();
    chk_beat("t3_b2", seg(16'h00E0, 7, 1, 0), 8'h80, 1'b0);
    out_req = 4'd0;
    tick();

    // 4: frame boundary blocks spanning into the next line
    out_req = 4'd8;
    offer(16'h00F0, 8'hC0, 1'b1);
    tick();
    offer(16'h0100, 8'hFF, 1'b0);
    tick();
    chk_beat("t4_P", seg(16'h00F0, 0, 2, 0), 8'hC0, 1'b1);
    idle();
    tick();
    chk_beat("t4_Z", seg(16'h0100, 0, 8, 0), 8'hFF, 1'b0);

    // 5: backpressure with zero request
    out_req = 4'd0;
    offer(16'h0110, 8'hFF, 1'b0);
    tick();
    offer(16'h0120, 8'hFF, 1'b0);
    tick();
    offer(16'h0130, 8'hFF, 1'b0);
    chk_rdy("t5_blk0", 1'b0);
    tick();
    chk_rdy("t5_blk1", 1'b0);
    chk_beat("t5_quiet", '0, 8'h00, 1'b0);
    out_req = 4'd8;
    tick();
    chk_beat("t5_L1", seg(16'h0110, 0, 8, 0), 8'hFF, 1'b0);
    chk_rdy("t5_reopen", 1'b1);
    tick();
    chk_beat("t5_L2", seg(16'h0120, 0, 8, 0), 8'hFF, 1'b0);
    idle();
    tick();
    chk_beat("t5_L3", seg(16'h0130, 0, 8, 0), 8'hFF, 1'b0);

    // 6: empty-frame marker, then reset with a half-drained line
    out_req = 4'd0;
    offer(16'h0140, 8'h00, 1'b1);
    tick();
    idle();
    tick();
    chk_beat("t6_marker", '0, 8'h00, 1'b1);
    tick();
    chk_beat("t6_after", '0, 8'h00, 1'b0);
    offer(16'h0150, 8'hFF, 1'b0);
    tick();
    idle();
    out_req = 4'd3;
    tick();
    chk_beat("t6_half", seg(16'h0150, 0, 3, 0), 8'hE0, 1'b0);
    rst = 1'b1;
    tick();
    chk_beat("t6_rst", '0, 8'h00, 1'b0);
    chk_rdy("t6_rst_rdy", 1'b0);
    rst = 1'b0;
    #1;
    chk_rdy("t6_rdy_low", 1'b0);
    tick();
    chk_rdy("t6_rdy_up", 1'b1);
    chk_beat("t6_flushed", '0, 8'h00, 1'b0);
    offer(16'h0160, 8'hFF, 1'b0);
    out_req = 4'd8;
    tick();
    idle();
    tick();
    chk_beat("t6_post", seg(16'h0160, 0, 8, 0), 8'hFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
